// File: rtl/definitions_pkg.sv
// Shared types and constants for the rv32i core.
// The fetch stage uses the word types, the fetch entry struct and the reset defaults.
package definitions_pkg;

  typedef logic        [31:0] word_ut;
  typedef logic signed [31:0] word_st;

  typedef struct packed {
    word_ut pc;
    word_st instr;
  } fetch_entry_t;

  localparam word_st NOP_INSTR        = 32'h0000_0013;
  localparam word_ut RESET_PC_DEFAULT = 32'h0000_0000;

  // Instructions are word-aligned, so the low two bits of any fetch target are dropped.
  function automatic word_ut align_word(input word_ut addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO between instruction fetch and decode.
// It has a single-cycle flush, and its head entry is readable at all times.
module fetch_fifo
  import definitions_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t entry_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Stale contents are never observed,
  // because every consumer qualifies the head with empty_o, and count is reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr] <= entry_i;
  end

  assign head_o  = mem[rd_ptr];
  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: owns the PC, reads the combinational instruction RAM,
// queues {pc, instr} pairs for decode, and handles redirects from execute.
module fetch_unit
  import definitions_pkg::*;
#(
  parameter word_ut RESET_PC = RESET_PC_DEFAULT,
  parameter int     DEPTH    = 2,
  parameter word_st NOP      = NOP_INSTR
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  output word_ut imem_addr_o,
  input  word_st imem_rdata_i,
  input  logic   redirect_i,
  input  word_ut redirect_pc_i,
  output logic   instr_valid_o,
  input  logic   instr_ready_i,
  output word_st instr_o,
  output word_ut instr_pc_o,
  output logic   misaligned_o
);

  word_ut       pc_q;
  logic         misaligned_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         push;
  fetch_entry_t new_entry;
  fetch_entry_t head;

  // A redirect overrides both sides. The FIFO flush drops the pop, and push is suppressed here.
  assign pop  = !fifo_empty && instr_ready_i;
  assign push = !redirect_i && (!fifo_full || pop);

  assign new_entry.pc    = pc_q;
  assign new_entry.instr = imem_rdata_i;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i (new_entry),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        pc_q <= align_word(redirect_pc_i);
      end else if (push) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // NOTE: every output of this block gets a default before the condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = NOP;
    instr_pc_o    = '0;
    if (!fifo_empty) begin
      instr_valid_o = 1'b1;
      instr_o       = head.instr;
      instr_pc_o    = head.pc;
    end
  end

  assign imem_addr_o  = pc_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A queue scoreboard checks every instruction decode
// accepts, and inline checks cover addresses, valid, misalignment and reset.
module tb_fetch_unit;
  import definitions_pkg::*;

  // RAM model: each word is its address XOR a fixed key.
  localparam word_ut RAM_KEY = 32'hA000_0013;

  logic   clk_i = 1'b0;
  logic   rst_ni = 1'b0;
  word_ut imem_addr_o;
  word_st imem_rdata_i;
  logic   redirect_i = 1'b0;
  word_ut redirect_pc_i = '0;
  logic   instr_valid_o;
  logic   instr_ready_i = 1'b0;
  word_st instr_o;
  word_ut instr_pc_o;
  logic   misaligned_o;

  int     vectors = 0;
  int     miscompares = 0;
  word_ut exp_q[$];
  word_ut mon_exp;

  always #5 clk_i = ~clk_i;

  assign imem_rdata_i = word_st'(imem_addr_o ^ RAM_KEY);

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .misaligned_o  (misaligned_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every accepted head outside a redirect/kill cycle must match the queue.
  always @(negedge clk_i) begin
    if (rst_ni && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got pc %h, expected no accept", instr_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_pc", instr_pc_o, mon_exp);
        check("sb_instr", instr_o, mon_exp ^ RAM_KEY);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_misaligned", 32'(misaligned_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);

    // Reset and stream: C0 is the first cycle after release
    rst_ni = 1'b1;
    check("c0_addr", imem_addr_o, 32'h0);
    check("c0_valid", 32'(instr_valid_o), 32'd0);
    instr_ready_i = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    tick();
    check("c1_valid", 32'(instr_valid_o), 32'd1);
    check("c1_addr", imem_addr_o, 32'h4);
    tick();
    tick();
    tick();

    // Redirect with a simultaneous pop: the pop of 0xC is killed
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    check("redir_valid", 32'(instr_valid_o), 32'd0);
    check("redir_addr", imem_addr_o, 32'h40);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    tick();
    check("redir_head_valid", 32'(instr_valid_o), 32'd1);
    tick();
    tick();

    // Misaligned redirect to 0x46 resumes from 0x44
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h46;
    tick();
    redirect_i = 1'b0;
    check("mis_pulse", 32'(misaligned_o), 32'd1);
    check("mis_addr", imem_addr_o, 32'h44);
    check("mis_valid", 32'(instr_valid_o), 32'd0);
    exp_q.push_back(32'h44);
    tick();
    check("mis_pulse_end", 32'(misaligned_o), 32'd0);
    tick();

    // PC wrap
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    check("wrap_mis", 32'(misaligned_o), 32'd0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    check("wrap_addr1", imem_addr_o, 32'h0);
    tick();
    tick();

    // Let the FIFO fill, then assert reset between clock edges
    instr_ready_i = 1'b0;
    tick();
    check("full_valid", 32'(instr_valid_o), 32'd1);
    check("full_addr", imem_addr_o, 32'hC);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_instr", instr_o, 32'h0000_0013);
    check("arst_pc", instr_pc_o, 32'h0);
    check("arst_addr", imem_addr_o, 32'h0);
    check("q_empty_stream", 32'(exp_q.size()), 32'd0);

    // Backpressure from reset: ready low for 5 cycles
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("bp_c1_valid", 32'(instr_valid_o), 32'd1);
    check("bp_c1_addr", imem_addr_o, 32'h4);
    tick();
    check("bp_c2_addr", imem_addr_o, 32'h8);
    tick();
    check("bp_c3_addr", imem_addr_o, 32'h8);
    tick();
    check("bp_c4_addr", imem_addr_o, 32'h8);
    check("bp_c4_head", instr_pc_o, 32'h0);
    tick();
    instr_ready_i = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    tick();
    tick();
    tick();
    instr_ready_i = 1'b0;
    check("bp_c8_head", instr_pc_o, 32'hC);
    tick();
    tick();
    check("q_empty_bp", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the rv32i core. Owns the program counter, drives the byte address into the combinational instruction RAM, and captures each returned word with its PC into a small FIFO. Hands instructions to decode over a valid/ready handshake. Accepts PC redirects from execute (branch, jump), which flush any queued instructions.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `DEPTH`, default `2`: FIFO entries. Power of two, ≥ 2.
- `NOP`, default `32'h0000_0013`: value driven on `instr_o` when the FIFO is empty.

Ports:
- `clk_i`  in  1: clock. Everything updates on the rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `imem_addr_o`  out  `word_ut`: byte address to instruction RAM. Always equals PC.
- `imem_rdata_i`  in  `word_st`: instruction word returned combinationally for `imem_addr_o`.
- `redirect_i`  in  1: load a new PC and flush the FIFO.
- `redirect_pc_i`  in  `word_ut`: target PC for a redirect.
- `instr_valid_o`  out  1: FIFO head holds a valid instruction.
- `instr_ready_i`  in  1: decode accepts the head this cycle.
- `instr_o`  out  `word_st`: head instruction, or `NOP` when the FIFO is empty.
- `instr_pc_o`  out  `word_ut`: PC of the head instruction, or 0 when the FIFO is empty.
- `misaligned_o`  out  1: one-cycle pulse, redirect target was not word-aligned.

## Operation
- **pop** = `instr_valid_o & instr_ready_i`.
- **push** = `!redirect_i & (!full | pop)`. On push:
  - write {PC, `imem_rdata_i`} at the tail;
  - PC ← PC + 4, modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- Full with no pop: no push, PC holds (stall). `imem_addr_o` stays stable.
- **redirect** takes priority over push and pop:
  - PC ← {`redirect_pc_i[31:2]`, 2'b00};
  - FIFO count ← 0, pointers reset;
  - no write that cycle. A simultaneous pop is discarded; decode must treat the redirect cycle as a kill.
- `misaligned_o` ← `redirect_i & (redirect_pc_i[1:0] != 0)`. It is registered and lasts one cycle. The fetch still proceeds from the aligned address.
- Occupancy counter is `$clog2(DEPTH)+1` bits.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- Outputs are driven from the head entry. Empty ⇔ count == 0, and `instr_valid_o` = (count != 0).

## Timing
- Reset (asynchronous assert):
  - PC = `RESET_PC`, count = 0, pointers = 0;
  - `instr_valid_o` = 0, `instr_o` = `NOP`, `instr_pc_o` = 0, `misaligned_o` = 0.
- Reset assertion mid-operation discards all queued entries immediately, without waiting for a clock edge.
- First cycle after reset release: `imem_addr_o` = `RESET_PC`, and a push happens at the edge. `instr_valid_o` = 1 from the next cycle.
- Fetch-to-decode latency is 1 cycle. With `instr_ready_i` held high, throughput is 1 instruction per cycle.
- Redirect at edge N:
  - cycle N+1: `imem_addr_o` = target, `instr_valid_o` = 0;
  - cycle N+2: target instruction valid at the head.
- Back-to-back redirects: the last one wins. No entry is pushed between them.
- All outputs are registered or decoded from registers. There is no combinational path from `instr_ready_i` or `redirect_i` to any output.

## Structure
- `definitions_pkg` gains:
  - `fetch_entry_t` (packed struct {`word_ut` pc; `word_st` instr});
  - `NOP_INSTR` = `32'h0000_0013`;
  - `RESET_PC_DEFAULT`.
- Sub-module `fetch_fifo`, parameterised on `DEPTH` and entry type, provides push/pop/flush with full/empty flags.
- `fetch_unit` holds the PC register, push/redirect control and misalignment detection.

## Test plan
- **Reset and stream.** Release reset, `instr_ready_i` = 1, RAM preloaded with words at 0x0, 0x4, 0x8. Required: `instr_pc_o` = 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after release, and `instr_o` matches the RAM contents.
- **Backpressure.** Hold `instr_ready_i` = 0 for 5 cycles. Required:
  - FIFO fills after 2 pushes and `imem_addr_o` holds 0x8;
  - on release, the head is 0x0, followed by 0x4 and 0x8, with no loss or duplication.
- **Redirect with pop.** While streaming, pulse `redirect_i` with target 0x40 and `instr_ready_i` = 1. Required:
  - `instr_valid_o` = 0 in the next cycle;
  - `imem_addr_o` = 0x40;
  - the head is pc 0x40 one cycle later;
  - no stale entries appear.
- **Misaligned redirect.** Redirect to 0x46. Required: `misaligned_o` = 1 for exactly one cycle, and fetch resumes from 0x44.
- **PC wrap.** Redirect to `32'hFFFF_FFFC`. Required: the following fetch address is 0x0 and the head PC sequence is FFFF_FFFC, 0000_0000.
- **Asynchronous reset mid-stream.** Assert `rst_ni` between clock edges while the FIFO is full. Required: `instr_valid_o` = 0 and `instr_o` = `NOP` immediately, and the PC returns to `RESET_PC`.
